// File: rtl/ddr_sched_pkg.sv
// Shared definitions for the DDR port scheduler.
// Holds the port count, the scheduler state encoding, the port-id type
// and the width of the outstanding-read credit counter.
package ddr_sched_pkg;
  localparam int NUM_PORTS      = 4;
  localparam int MAX_RD_OUT_DEF = 16;
  // Wide enough to hold the value MAX_RD_OUT itself, not just MAX_RD_OUT-1.
  localparam int CRED_W         = $clog2(MAX_RD_OUT_DEF + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } state_t;

  typedef logic [1:0] port_id_t;
endpackage

// File: rtl/ddr_rr_pick.sv
// Combinational rotating priority encoder.
// Searches i_elig starting at the port after i_ptr and wrapping around.
// i_ptr itself has the lowest priority.
// Ports:
//   i_elig   - eligible request vector
//   i_ptr    - last served port; the search starts one past it
//   o_onehot - one-hot winner (zero when nothing is eligible)
//   o_id     - encoded winner
//   o_any    - at least one eligible port
module ddr_rr_pick
  import ddr_sched_pkg::*;
(
  input  logic [NUM_PORTS-1:0] i_elig,
  input  port_id_t             i_ptr,
  output logic [NUM_PORTS-1:0] o_onehot,
  output port_id_t             o_id,
  output logic                 o_any
);

  port_id_t w_idx;

  // Walk from the farthest candidate to the nearest so that the nearest
  // eligible port overwrites the earlier ones and wins.
  always_comb begin
    o_onehot = '0;
    o_id     = '0;
    o_any    = |i_elig;
    w_idx    = '0;
    for (int k = NUM_PORTS; k >= 1; k--) begin
      w_idx = i_ptr + k[1:0];
      if (i_elig[w_idx]) begin
        o_onehot        = '0;
        o_onehot[w_idx] = 1'b1;
        o_id            = w_idx;
      end
    end
  end

endmodule

// File: rtl/ddr_port_scheduler.sv
// Weighted round-robin owner of the shared DDR command/write path.
// Each grant is held for a per-port burst quota.
// Read grants are masked while the outstanding-read credit pool is full.
// Starving ports force a hand-over at the next accepted transaction.
// Ports:
//   i_clk, i_rst_n      - clock, async active-low reset
//   i_req, i_is_rd      - per-port request and request type (1 = read)
//   i_xfer_done         - granted transaction accepted by DDR
//   i_rd_data_valid     - read beat returned; frees one credit
//   i_quota_we/port/val - quota register write
//   o_grant, o_grant_id, o_grant_valid - registered grant
//   o_rd_outstanding, o_rd_full        - read credit state
//   o_err                - sticky credit-underflow flag
module ddr_port_scheduler
  import ddr_sched_pkg::*;
#(
  parameter int QW           = 8,
  parameter int DEF_QUOTA    = 8,
  parameter int MAX_RD_OUT   = 16,
  parameter int STARVE_LIMIT = 64
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [NUM_PORTS-1:0] i_req,
  input  logic [NUM_PORTS-1:0] i_is_rd,
  input  logic                 i_xfer_done,
  input  logic                 i_rd_data_valid,
  input  logic                 i_quota_we,
  input  logic [1:0]           i_quota_port,
  input  logic [QW-1:0]        i_quota_val,
  output logic [NUM_PORTS-1:0] o_grant,
  output logic [1:0]           o_grant_id,
  output logic                 o_grant_valid,
  output logic [CRED_W-1:0]    o_rd_outstanding,
  output logic                 o_rd_full,
  output logic                 o_err
);

  localparam int AW = $clog2(STARVE_LIMIT + 1);

  state_t                          r_state;
  logic [NUM_PORTS-1:0]            r_grant;
  port_id_t                        r_grant_id;
  logic                            r_grant_valid;
  port_id_t                        r_ptr;
  logic [NUM_PORTS-1:0][QW-1:0]    r_quota;
  logic [QW-1:0]                   r_remain;
  logic [NUM_PORTS-1:0][AW-1:0]    r_age;
  logic [CRED_W-1:0]               r_rd_cnt;
  logic                            r_err;

  logic [NUM_PORTS-1:0] w_elig;
  logic [NUM_PORTS-1:0] w_starved;
  logic [NUM_PORTS-1:0] w_starve_elig;
  logic [NUM_PORTS-1:0] w_st_oh, w_rr_oh, w_win_oh;
  port_id_t             w_st_id, w_rr_id, w_win_id;
  logic                 w_st_any, w_rr_any;
  logic [QW-1:0]        w_load_q, w_load_rem;
  logic                 w_done_rd, w_other_starve, w_release;

  assign o_rd_full = (r_rd_cnt == CRED_W'(MAX_RD_OUT));
  assign w_elig    = i_req & ~(i_is_rd & {NUM_PORTS{o_rd_full}});

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_starve
    assign w_starved[gi] = (r_age[gi] >= AW'(STARVE_LIMIT));
  end
  // A starving reader that cannot be served yet must not pre-empt anyone.
  assign w_starve_elig = w_starved & w_elig;

  // The starvation pick uses a fixed pointer of 3, so the lowest index wins.
  ddr_rr_pick u_pick_starve (
    .i_elig   (w_starve_elig),
    .i_ptr    (port_id_t'(3)),
    .o_onehot (w_st_oh),
    .o_id     (w_st_id),
    .o_any    (w_st_any)
  );

  ddr_rr_pick u_pick_rr (
    .i_elig   (w_elig),
    .i_ptr    (r_ptr),
    .o_onehot (w_rr_oh),
    .o_id     (w_rr_id),
    .o_any    (w_rr_any)
  );

  assign w_win_oh   = w_st_any ? w_st_oh : w_rr_oh;
  assign w_win_id   = w_st_any ? w_st_id : w_rr_id;
  assign w_load_q   = r_quota[w_win_id];
  assign w_load_rem = (w_load_q == '0) ? QW'(1) : w_load_q;

  assign w_done_rd      = i_xfer_done & r_grant_valid & i_is_rd[r_grant_id];
  assign w_other_starve = |(w_starve_elig & ~r_grant);
  assign w_release      = (i_xfer_done && (r_remain == QW'(1))) ||
                          !w_elig[r_grant_id] ||
                          (i_xfer_done && w_other_starve);

  // Grant FSM. Every release passes through IDLE for one cycle, so the
  // downstream port mux never switches in the middle of a transaction.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= IDLE;
      r_grant       <= '0;
      r_grant_id    <= '0;
      r_grant_valid <= 1'b0;
      r_ptr         <= port_id_t'(3);
      r_remain      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_rr_any) begin
            r_grant       <= w_win_oh;
            r_grant_id    <= w_win_id;
            r_grant_valid <= 1'b1;
            r_ptr         <= w_win_id;
            r_remain      <= w_load_rem;
            r_state       <= SERVE;
          end
        end
        SERVE: begin
          if (w_release) begin
            r_grant       <= '0;
            r_grant_valid <= 1'b0;
            r_state       <= IDLE;
          end else if (i_xfer_done) begin
            r_remain <= r_remain - QW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // A write lands in the register only at the edge, so a load in the same
  // cycle still reads the old quota.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_PORTS; i++) r_quota[i] <= QW'(DEF_QUOTA);
    end else begin
      for (int i = 0; i < NUM_PORTS; i++)
        if (i_quota_we && (i_quota_port == port_id_t'(i)))
          r_quota[i] <= i_quota_val;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_PORTS; i++) r_age[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (i_req[i] && !r_grant[i]) begin
          if (r_age[i] < AW'(STARVE_LIMIT)) r_age[i] <= r_age[i] + AW'(1);
        end else begin
          r_age[i] <= '0;
        end
      end
    end
  end

  // The increment is also guarded at full, because one done can still
  // arrive in the cycle before the full reader is released.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_cnt <= '0;
      r_err    <= 1'b0;
    end else begin
      case ({w_done_rd, i_rd_data_valid})
        2'b10: if (!o_rd_full) r_rd_cnt <= r_rd_cnt + CRED_W'(1);
        2'b01: begin
          if (r_rd_cnt == '0) r_err <= 1'b1;
          else                r_rd_cnt <= r_rd_cnt - CRED_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign o_grant          = r_grant;
  assign o_grant_id       = r_grant_id;
  assign o_grant_valid    = r_grant_valid;
  assign o_rd_outstanding = r_rd_cnt;
  assign o_err            = r_err;

endmodule

// File: tb/tb_ddr_port_scheduler.sv
module tb_ddr_port_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req, is_rd;
  logic       done, rdv, qwe;
  logic [1:0] qport;
  logic [7:0] qval;
  logic [3:0] grant;
  logic [1:0] grant_id;
  logic       grant_valid;
  logic [4:0] rd_out;
  logic       rd_full, err;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ddr_port_scheduler dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_req            (req),
    .i_is_rd          (is_rd),
    .i_xfer_done      (done),
    .i_rd_data_valid  (rdv),
    .i_quota_we       (qwe),
    .i_quota_port     (qport),
    .i_quota_val      (qval),
    .o_grant          (grant),
    .o_grant_id       (grant_id),
    .o_grant_valid    (grant_valid),
    .o_rd_outstanding (rd_out),
    .o_rd_full        (rd_full),
    .o_err            (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    $display("check %-16s observed=0x%0h expected=0x%0h", tag, obs, exp);
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = '0; is_rd = '0; done = 1'b0; rdv = 1'b0;
    qwe = 1'b0; qport = '0; qval = '0;
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic quota_wr(input logic [1:0] p, input logic [7:0] v);
    qwe = 1'b1; qport = p; qval = v;
    step(1);
    qwe = 1'b0;
  endtask

  logic [3:0] exp_rr [13];

  initial begin
    exp_rr = '{4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h0, 4'h4, 4'h4, 4'h0,
               4'h8, 4'h8, 4'h0, 4'h1};

    // Reset state
    do_reset();
    chk("rst_grant", {28'd0, grant}, 0);
    chk("rst_gvalid_id", {29'd0, grant_valid, grant_id}, 0);
    chk("rst_rd_out", {27'd0, rd_out}, 0);
    chk("rst_full_err", {30'd0, rd_full, err}, 0);

    // Single writer, default quota 8
    req = 4'b0001;
    step(1);
    chk("p0_grant_c1", {28'd0, grant}, 4'b0001);
    chk("p0_grant_id", {30'd0, grant_id}, 0);
    done = 1'b1;
    step(7);
    chk("p0_after7", {28'd0, grant}, 4'b0001);
    step(1);
    chk("p0_released", {28'd0, grant}, 4'b0000);
    done = 1'b0;
    step(1);
    chk("p0_regrant", {28'd0, grant}, 4'b0001);

    // Four writers, quota 2 each, done every cycle
    do_reset();
    for (int p = 0; p < 4; p++) quota_wr(p[1:0], 8'd2);
    req = 4'b1111; done = 1'b1;
    for (int i = 0; i < 13; i++) begin
      step(1);
      chk($sformatf("rr_seq_%0d", i), {28'd0, grant}, {28'd0, exp_rr[i]});
    end
    req = '0; done = 1'b0;

    // Reader on port 2 fills the credit pool
    do_reset();
    quota_wr(2'd2, 8'd16);
    req = 4'b0100; is_rd = 4'b0100;
    step(1);
    chk("rd_grant", {28'd0, grant}, 4'b0100);
    done = 1'b1;
    step(15);
    chk("rd_cnt15", {27'd0, rd_out}, 15);
    chk("rd_grant15", {28'd0, grant}, 4'b0100);
    step(1);
    chk("rd_cnt16", {27'd0, rd_out}, 16);
    chk("rd_full", {31'd0, rd_full}, 1);
    chk("rd_released", {28'd0, grant}, 4'b0000);
    done = 1'b0;
    step(3);
    chk("rd_no_regrant", {28'd0, grant}, 4'b0000);
    rdv = 1'b1;
    step(1);
    rdv = 1'b0;
    chk("rd_credit_back", {27'd0, rd_out}, 15);
    chk("rd_gnt_bubble", {28'd0, grant}, 4'b0000);
    step(1);
    chk("rd_regrant", {28'd0, grant}, 4'b0100);
    rdv = 1'b1;
    step(10);
    chk("rd_cnt5", {27'd0, rd_out}, 5);
    done = 1'b1;
    step(1);
    done = 1'b0;
    chk("rd_both_same", {27'd0, rd_out}, 5);
    step(5);
    chk("rd_cnt0", {27'd0, rd_out}, 0);
    chk("rd_no_err_yet", {31'd0, err}, 0);
    step(1);
    rdv = 1'b0;
    chk("rd_underflow_err", {31'd0, err}, 1);
    chk("rd_underflow_cnt", {27'd0, rd_out}, 0);
    step(2);
    chk("rd_err_sticky", {31'd0, err}, 1);

    // Starvation: port 0 with big quota, port 3 waiting
    do_reset();
    quota_wr(2'd0, 8'd255);
    req = 4'b1001; is_rd = '0;
    step(1);
    chk("st_p0_grant", {28'd0, grant}, 4'b0001);
    step(63);
    chk("st_p0_held", {28'd0, grant}, 4'b0001);
    chk("st_age64", {25'd0, dut.r_age[3]}, 64);
    done = 1'b1;
    step(1);
    done = 1'b0;
    chk("st_released", {28'd0, grant}, 4'b0000);
    step(1);
    chk("st_p3_grant", {28'd0, grant}, 4'b1000);
    chk("st_p3_id", {30'd0, grant_id}, 3);
    step(1);
    chk("st_age_clr", {25'd0, dut.r_age[3]}, 0);

    // Quota rewrite during service
    do_reset();
    quota_wr(2'd1, 8'd5);
    req = 4'b0010;
    step(1);
    chk("q_grant", {28'd0, grant}, 4'b0010);
    quota_wr(2'd1, 8'd3);
    done = 1'b1;
    step(4);
    chk("q_after4", {28'd0, grant}, 4'b0010);
    step(1);
    chk("q_release5", {28'd0, grant}, 4'b0000);
    step(1);
    chk("q_regrant", {28'd0, grant}, 4'b0010);
    step(2);
    chk("q_after2", {28'd0, grant}, 4'b0010);
    step(1);
    chk("q_release3", {28'd0, grant}, 4'b0000);
    done = 1'b0;
    step(1);
    chk("q_serve_again", {28'd0, grant}, 4'b0010);

    // Asynchronous reset in the middle of a grant
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_grant", {28'd0, grant}, 4'b0000);
    chk("arst_gvalid", {31'd0, grant_valid}, 0);
    req = 4'b1111;
    step(1);
    rst_n = 1'b1;
    step(1);
    chk("arst_p0_first", {28'd0, grant}, 4'b0001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
